// File: rtl/gtech_parity_checker.sv
// Receive-side parity checker: checks each word against its parity bit, forwards it
// through one registered stage with an error tag, and keeps error status counters.
module gtech_parity_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ODD   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_PAR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_ERR,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             ERR_STICKY,
  input  logic             CLR_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               in_xfer, out_xfer, syndrome;
  logic [WIDTH-1:0]   data_d;
  logic               err_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               sticky_d;

  // OUT_VALID is a direct decode of the state flop; IN_READY is the only comb path.
  assign OUT_VALID = (state_q == FULL);
  assign IN_READY  = ~OUT_VALID | OUT_READY;
  assign in_xfer   = IN_VALID & IN_READY;
  assign out_xfer  = OUT_VALID & OUT_READY;
  assign syndrome  = (^IN_DATA) ^ IN_PAR ^ 1'(ODD);

  // Next-state, datapath load and counter update.
  always_comb begin
    state_d  = state_q;
    data_d   = OUT_DATA;
    err_d    = OUT_ERR;
    cnt_d    = ERR_CNT;
    sticky_d = ERR_STICKY;

    case (state_q)
      EMPTY:   if (in_xfer) state_d = FULL;
      FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (in_xfer) begin
      data_d = IN_DATA;
      err_d  = syndrome;
    end

    if (CLR_ERR) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end

    // An error accepted on the clearing edge survives the clear.
    if (in_xfer && syndrome) begin
      sticky_d = 1'b1;
      if (CLR_ERR) begin
        cnt_d = CNT_W'(1);
      end else if (ERR_CNT != CNT_MAX) begin
        cnt_d = ERR_CNT + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q    <= EMPTY;
      OUT_DATA   <= '0;
      OUT_ERR    <= 1'b0;
      ERR_CNT    <= '0;
      ERR_STICKY <= 1'b0;
    end else begin
      state_q    <= state_d;
      OUT_DATA   <= data_d;
      OUT_ERR    <= err_d;
      ERR_CNT    <= cnt_d;
      ERR_STICKY <= sticky_d;
    end
  end

endmodule

// File: tb/tb_gtech_parity_checker.sv
// Randomized and directed bench for gtech_parity_checker: an even-parity/3-bit-counter
// instance and an odd-parity/8-bit-counter instance share stimulus against a queue model.
module tb_gtech_parity_checker;

  logic       cp, cd, in_valid, in_par, out_ready, clr_err;
  logic [7:0] in_data;

  logic       in_ready0, out_valid0, out_err0, sticky0;
  logic [7:0] out_data0;
  logic [2:0] err_cnt0;
  logic       in_ready1, out_valid1, out_err1, sticky1;
  logic [7:0] out_data1;
  logic [7:0] err_cnt1;

  int checks = 0;
  int failures = 0;

  gtech_parity_checker #(.WIDTH(8), .ODD(0), .CNT_W(3)) u_even (
    .CP(cp), .CD(cd), .IN_VALID(in_valid), .IN_READY(in_ready0), .IN_DATA(in_data),
    .IN_PAR(in_par), .OUT_VALID(out_valid0), .OUT_READY(out_ready), .OUT_DATA(out_data0),
    .OUT_ERR(out_err0), .ERR_CNT(err_cnt0), .ERR_STICKY(sticky0), .CLR_ERR(clr_err)
  );

  gtech_parity_checker #(.WIDTH(8), .ODD(1), .CNT_W(8)) u_odd (
    .CP(cp), .CD(cd), .IN_VALID(in_valid), .IN_READY(in_ready1), .IN_DATA(in_data),
    .IN_PAR(in_par), .OUT_VALID(out_valid1), .OUT_READY(out_ready), .OUT_DATA(out_data1),
    .OUT_ERR(out_err1), .ERR_CNT(err_cnt1), .ERR_STICKY(sticky1), .CLR_ERR(clr_err)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: the output stage is a one-deep queue of tagged words.
  typedef struct packed {
    logic [7:0] d;
    logic       e0;
    logic       e1;
  } word_t;

  word_t q[$];
  word_t last;
  int    cnt0, cnt1, delivered;
  bit    st0, st1;

  function automatic logic is_err(input logic [7:0] d, input logic p, input int odd);
    return ((($countones(d) + int'(p) + odd) % 2) == 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    cnt0 = 0;
    cnt1 = 0;
    st0  = 1'b0;
    st1  = 1'b0;
  endtask

  task automatic check_outputs();
    word_t e;
    e = (q.size() != 0) ? q[0] : last;
    check_eq("out_valid0", 32'(out_valid0), 32'(q.size() != 0));
    check_eq("out_valid1", 32'(out_valid1), 32'(q.size() != 0));
    check_eq("out_data0",  32'(out_data0),  32'(e.d));
    check_eq("out_data1",  32'(out_data1),  32'(e.d));
    check_eq("out_err0",   32'(out_err0),   32'(e.e0));
    check_eq("out_err1",   32'(out_err1),   32'(e.e1));
    check_eq("err_cnt0",   32'(err_cnt0),   32'(cnt0));
    check_eq("err_cnt1",   32'(err_cnt1),   32'(cnt1));
    check_eq("sticky0",    32'(sticky0),    32'(st0));
    check_eq("sticky1",    32'(sticky1),    32'(st1));
  endtask

  // Called just after a negedge with inputs set; advances one clock and checks.
  task automatic cycle();
    bit    rdy, ix, ox, e0, e1;
    word_t w;
    #1;
    rdy = (q.size() == 0) || out_ready;
    check_eq("in_ready0", 32'(in_ready0), 32'(rdy));
    check_eq("in_ready1", 32'(in_ready1), 32'(rdy));
    ix = in_valid && rdy;
    ox = (q.size() != 0) && out_ready;
    e0 = is_err(in_data, in_par, 0);
    e1 = is_err(in_data, in_par, 1);
    @(posedge cp);
    if (ox) begin
      void'(q.pop_front());
      delivered++;
    end
    if (clr_err) begin
      cnt0 = 0; cnt1 = 0; st0 = 1'b0; st1 = 1'b0;
    end
    if (ix) begin
      w = '{d: in_data, e0: e0, e1: e1};
      q.push_back(w);
      last = w;
      if (e0) begin cnt0 = (cnt0 + 1 > 7) ? 7 : cnt0 + 1; st0 = 1'b1; end
      if (e1) begin cnt1 = (cnt1 + 1 > 255) ? 255 : cnt1 + 1; st1 = 1'b1; end
    end
    @(negedge cp);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d, input logic p, input logic ordy);
    in_valid  = 1'b1;
    in_data   = d;
    in_par    = p;
    out_ready = ordy;
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"},  32'({out_valid0, out_valid1}), 32'(0));
    check_eq({tag, "_data"},   32'({out_data0, out_data1}), 32'(0));
    check_eq({tag, "_err"},    32'({out_err0, out_err1}), 32'(0));
    check_eq({tag, "_cnt"},    32'({err_cnt0, err_cnt1}), 32'(0));
    check_eq({tag, "_sticky"}, 32'({sticky0, sticky1}), 32'(0));
    check_eq({tag, "_ready"},  32'({in_ready0, in_ready1}), 32'(2'b11));
  endtask

  initial begin
    int sent, start, cyc;

    // Reset with random inputs, then idle.
    cd = 1'b0;
    model_reset();
    delivered = 0;
    repeat (3) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); in_par = 1'($urandom);
      out_ready = 1'($urandom); clr_err = 1'($urandom);
      @(negedge cp);
      #1;
      check_reset_values("reset");
    end
    in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    cd = 1'b1;
    repeat (5) cycle();

    // Even parity single words.
    send(8'hA5, 1'b0, 1'b1);
    check_eq("even_a5p0_data", 32'(out_data0), 32'h00A5);
    check_eq("even_a5p0_err", 32'(out_err0), 32'(0));
    send(8'hA5, 1'b1, 1'b1);
    check_eq("even_a5p1_err", 32'(out_err0), 32'(1));
    check_eq("even_a5p1_cnt", 32'(err_cnt0), 32'(1));
    check_eq("even_a5p1_sticky", 32'(sticky0), 32'(1));

    // Odd parity single words.
    send(8'h01, 1'b0, 1'b1);
    check_eq("odd_01p0_err", 32'(out_err1), 32'(0));
    send(8'h03, 1'b0, 1'b1);
    check_eq("odd_03p0_err", 32'(out_err1), 32'(1));
    cycle();

    // Backpressure: OUT_READY low in cycles 2..4 of the stream.
    sent = 0;
    start = delivered;
    cyc = 0;
    while ((delivered - start < 6) && (cyc < 40)) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 6);
      in_data   = 8'h10 + 8'(sent);
      in_par    = 1'b0;
      if (cyc >= 2 && cyc <= 4) begin
        #1;
        check_eq("bp_in_ready", 32'(in_ready0), 32'(0));
        check_eq("bp_hold_data", 32'(out_data0), 32'h0011);
      end
      if (in_valid && ((q.size() == 0) || out_ready)) sent++;
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("bp_delivered", 32'(delivered - start), 32'(6));

    // Full throughput: one word accepted every cycle.
    out_ready = 1'b1;
    start = delivered;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h20 + 8'(i); in_par = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check_eq("thru_delivered", 32'(delivered - start), 32'(6));

    // Saturation of the 3-bit counter and clearing.
    clr_err = 1'b1;
    cycle();
    clr_err = 1'b0;
    check_eq("clr0_cnt", 32'(err_cnt0), 32'(0));
    for (int i = 0; i < 9; i++) send(8'h01, 1'b0, 1'b1);
    check_eq("sat_cnt", 32'(err_cnt0), 32'(7));
    check_eq("sat_sticky", 32'(sticky0), 32'(1));
    clr_err = 1'b1;
    cycle();
    check_eq("clr_cnt", 32'(err_cnt0), 32'(0));
    check_eq("clr_sticky", 32'(sticky0), 32'(0));
    send(8'h01, 1'b0, 1'b1);
    clr_err = 1'b0;
    check_eq("clr_err_same_cnt", 32'(err_cnt0), 32'(1));
    check_eq("clr_err_same_sticky", 32'(sticky0), 32'(1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_par    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0; clr_err = 1'b0;

    // Asynchronous reset while a word is held.
    send(8'h77, 1'b1, 1'b0);
    #2;
    cd = 1'b0;
    #1;
    model_reset();
    check_reset_values("midrst");
    @(posedge cp);
    @(negedge cp);
    cd = 1'b1;
    send(8'h3C, 1'b0, 1'b1);
    check_eq("post_rst_valid", 32'(out_valid0), 32'(1));
    check_eq("post_rst_data", 32'(out_data0), 32'h003C);
    check_eq("post_rst_err", 32'(out_err0), 32'(0));
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
